sti_pixel_packer: RTL



---
 rtl/sti_pixel_packer.sv | 99 +++++++++
 1 files changed

// File: rtl/sti_pixel_packer.sv
// Serial-to-parallel packer: gathers so_data bits MSB-first into bytes and
// writes them to a pixel memory at auto-incrementing addresses until it is full.
module sti_pixel_packer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              so_data,
  input  logic              so_valid,
  input  logic              flush,
  output logic [7:0]        pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_wr,
  output logic              pix_finish
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {COLLECT, DONE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              finish_q, finish_d;

  logic [7:0] shNext;
  logic [2:0] cntNext;
  logic [3:0] padShift;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    addr_d   = addr_q;
    wr_d     = 1'b0;
    finish_d = finish_q;
    shNext   = so_valid ? {sh_q[6:0], so_data} : sh_q;
    cntNext  = cnt_q + {2'b00, so_valid};
    padShift = 4'd8 - {1'b0, cntNext};

    if (state_q == COLLECT) begin
      if (wr_q && (addr_q == LastAddr)) begin
        // Final location written: stop here, address stays parked on the last slot.
        state_d  = DONE;
        finish_d = 1'b1;
      end else begin
        if (wr_q) begin
          addr_d = addr_q + 1'b1;
        end
        if (so_valid && (cnt_q == 3'd7)) begin
          data_d = shNext;
          wr_d   = 1'b1;
          sh_d   = shNext;
          cnt_d  = 3'd0;
        end else if (flush && (cntNext != 3'd0)) begin
          // Stale upper bits of shNext fall off the top when left-aligning.
          data_d = shNext << padShift;
          wr_d   = 1'b1;
          sh_d   = 8'h00;
          cnt_d  = 3'd0;
        end else begin
          sh_d  = shNext;
          cnt_d = cntNext;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= COLLECT;
      sh_q     <= 8'h00;
      cnt_q    <= 3'd0;
      data_q   <= 8'h00;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      finish_q <= finish_d;
    end
  end

  assign pix_data   = data_q;
  assign pix_addr   = addr_q;
  assign pix_wr     = wr_q;
  assign pix_finish = finish_q;

endmodule
